shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with valid/ready handshakes on both sides. It generalises the team's fixed-amount right shifters with three additions: a run-time shift amount, four shift modes, and a log2(N)-stage registered pipeline with full-throughput backpressure. It sits between a streaming producer and consumer in datapath blocks that need per-word variable shifts.

---
 rtl/shift_pipe.sv | 144 ++++++++++++++
 tb/tb_shift_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: run-time barrel shifter (LSR/ASR/ROR/LSL), one amount bit resolved per stage.
// Latency: SW = $clog2(N) stages; an accepted word is on out_data after SW-1 further edges.
// Backpressure: in_ready is combinational from out_ready; stalled stages hold, bubbles collapse.
module shift_pipe #(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [SW-1:0] in_amt,
   input  logic [1:0]    in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          busy
);

   // Control (amount/mode/sign) is only needed by stages that feed another stage.
   localparam int CS = (SW > 1) ? SW - 1 : 1;

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;

   logic [SW-1:0]         vld_q, vld_d, ld;
   logic [SW-1:0][N-1:0]  dat_q, dat_d;
   logic [CS-1:0][SW-1:0] amt_q, amt_d;
   logic [CS-1:0][1:0]    mode_q, mode_d;
   logic [CS-1:0]         sgn_q, sgn_d;

   // Per-stage source view: index 0 is the input port, index k is stage k-1.
   logic [SW-1:0]         src_vld, src_sgn;
   logic [SW-1:0][N-1:0]  src_dat;
   logic [SW-1:0][SW-1:0] src_amt;
   logic [SW-1:0][1:0]    src_mode;

   // One stage's conditional shift by a fixed distance sh; the sign travels with the
   // word so arithmetic fill stays correct after earlier stages have moved the MSB.
   function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d, input logic en,
                                                input logic [1:0] mode, input logic sgn,
                                                input int sh);
      logic [2*N-1:0] ext;
      logic [N-1:0]   res;
      ext = '0;
      res = d;
      if (en) begin
         case (mode)
            MODE_LSR: ext = {{N{1'b0}}, d} >> sh;
            MODE_ASR: ext = {{N{sgn}}, d} >> sh;
            MODE_ROR: ext = {d, d} >> sh;
            default:  ext = {{N{1'b0}}, d << sh};
         endcase
         res = ext[N-1:0];
      end
      return res;
   endfunction

   // Stage k may load unless it and every stage after it are full while the consumer stalls.
   always_comb begin
      logic full;
      full = 1'b1;
      ld   = '0;
      for (int k = 0; k < SW; k++) begin
         full = 1'b1;
         for (int j = k; j < SW; j++) begin
            full = full & vld_q[j];
         end
         ld[k] = !full || out_ready;
      end
   end

   // Route each stage's upstream word and control into a uniform source view.
   always_comb begin
      src_vld  = '0;
      src_dat  = '0;
      src_amt  = '0;
      src_mode = '0;
      src_sgn  = '0;
      src_vld[0]  = in_valid;
      src_dat[0]  = in_data;
      src_amt[0]  = in_amt;
      src_mode[0] = in_mode;
      src_sgn[0]  = in_data[N-1];
      for (int k = 1; k < SW; k++) begin
         src_vld[k]  = vld_q[k-1];
         src_dat[k]  = dat_q[k-1];
         src_amt[k]  = amt_q[k-1];
         src_mode[k] = mode_q[k-1];
         src_sgn[k]  = sgn_q[k-1];
      end
   end

   // Next state: loading stages take their source (shifted), blocked stages hold.
   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      amt_d  = amt_q;
      mode_d = mode_q;
      sgn_d  = sgn_q;
      for (int k = 0; k < SW; k++) begin
         if (ld[k]) begin
            vld_d[k] = src_vld[k];
            if (src_vld[k]) begin
               dat_d[k] = stage_shift(src_dat[k], src_amt[k][0], src_mode[k],
                                      src_sgn[k], 1 << k);
            end
         end
      end
      // Amount is consumed LSB first, so each stage passes it on shifted down by one.
      for (int k = 0; k < SW - 1; k++) begin
         if (ld[k] && src_vld[k]) begin
            amt_d[k]  = src_amt[k] >> 1;
            mode_d[k] = src_mode[k];
            sgn_d[k]  = src_sgn[k];
         end
      end
   end

   // Pipeline registers; reset empties the pipe and clears all data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         dat_q  <= '0;
         amt_q  <= '0;
         mode_q <= '0;
         sgn_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         amt_q  <= amt_d;
         mode_q <= mode_d;
         sgn_q  <= sgn_d;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld_q[SW-1];
   assign out_data  = dat_q[SW-1];
   assign busy      = |vld_q;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed vectors with hand-computed results for shift_pipe.
// Covers modes, amount sweep, stall/backpressure, full-pipe turnover, mid-run reset, N=32.
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_shift_pipe;

   logic        clk;
   logic        rst_n;

   logic        i8_vld, i8_rdy, o8_vld, o8_rdy, busy8;
   logic [7:0]  i8_dat, o8_dat;
   logic [2:0]  i8_amt;
   logic [1:0]  i8_mode;

   logic        i32_vld, i32_rdy, o32_vld, o32_rdy, busy32;
   logic [31:0] i32_dat, o32_dat;
   logic [4:0]  i32_amt;
   logic [1:0]  i32_mode;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] t_dat  [16];
   logic [7:0] t_exp  [16];
   logic [2:0] t_amt  [16];
   logic [1:0] t_mode [16];

   shift_pipe #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(i8_vld), .in_ready(i8_rdy), .in_data(i8_dat), .in_amt(i8_amt),
      .in_mode(i8_mode), .out_valid(o8_vld), .out_ready(o8_rdy), .out_data(o8_dat),
      .busy(busy8)
   );

   shift_pipe #(.N(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(i32_vld), .in_ready(i32_rdy), .in_data(i32_dat), .in_amt(i32_amt),
      .in_mode(i32_mode), .out_valid(o32_vld), .out_ready(o32_rdy), .out_data(o32_dat),
      .busy(busy32)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [7:0] d, input logic [2:0] a,
                          input logic [1:0] m, input logic [7:0] e);
      t_dat[i]  = d;
      t_amt[i]  = a;
      t_mode[i] = m;
      t_exp[i]  = e;
   endtask

   task automatic cyc8(input logic v, input logic [7:0] d, input logic [2:0] a,
                       input logic [1:0] m, input logic r);
      @(negedge clk);
      i8_vld  = v;
      i8_dat  = d;
      i8_amt  = a;
      i8_mode = m;
      o8_rdy  = r;
      #1;
   endtask

   task automatic cyc32(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] m, input logic r);
      @(negedge clk);
      i32_vld  = v;
      i32_dat  = d;
      i32_amt  = a;
      i32_mode = m;
      o32_rdy  = r;
      #1;
   endtask

   // Stream n table words into the N=8 pipe; out_ready is low for cycles st_lo..st_hi.
   task automatic run8(input int n, input int st_lo, input int st_hi, input logic lat_chk);
      int sent;
      int rcv;
      int c;
      int acc_c[$];
      sent = 0;
      rcv  = 0;
      c    = 0;
      while (rcv < n && c < 200) begin
         c++;
         @(negedge clk);
         i8_vld = (sent < n);
         if (sent < n) begin
            i8_dat  = t_dat[sent];
            i8_amt  = t_amt[sent];
            i8_mode = t_mode[sent];
         end
         o8_rdy = !(c >= st_lo && c <= st_hi);
         #1;
         check("in_rdy", {31'b0, i8_rdy}, {31'b0, ((sent - rcv) < 3) || o8_rdy});
         if (o8_vld) begin
            check("out_dat", {24'b0, o8_dat}, {24'b0, t_exp[rcv]});
            if (o8_rdy) begin
               if (lat_chk && acc_c.size() > 0) check("latency", c - acc_c[0], 3);
               if (acc_c.size() > 0) void'(acc_c.pop_front());
               rcv++;
            end
         end
         if (i8_vld && i8_rdy) begin
            acc_c.push_back(c);
            sent++;
         end
      end
      if (rcv < n) check("stream_timeout", rcv, n);
      @(negedge clk);
      i8_vld = 1'b0;
      o8_rdy = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b1;
      i8_vld   = 1'b0; i8_dat  = '0; i8_amt  = '0; i8_mode  = '0; o8_rdy  = 1'b1;
      i32_vld  = 1'b0; i32_dat = '0; i32_amt = '0; i32_mode = '0; o32_rdy = 1'b1;

      // Reset state
      #3 rst_n = 1'b0;
      #1;
      check("rst_out_vld", {31'b0, o8_vld}, 0);
      check("rst_busy", {31'b0, busy8}, 0);
      check("rst_out_dat", {24'b0, o8_dat}, 0);
      check("rst_in_rdy", {31'b0, i8_rdy}, 1);
      check("rst_out_dat32", o32_dat, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Four modes on 0xB4, amount 3
      set_vec(0, 8'hB4, 3'd3, 2'b00, 8'h16);
      set_vec(1, 8'hB4, 3'd3, 2'b01, 8'hF6);
      set_vec(2, 8'hB4, 3'd3, 2'b10, 8'h96);
      set_vec(3, 8'hB4, 3'd3, 2'b11, 8'hA0);
      run8(4, 100, 0, 1'b1);

      // Rotate-right amount sweep, back-to-back
      set_vec(0, 8'h81, 3'd0, 2'b10, 8'h81);
      set_vec(1, 8'h81, 3'd1, 2'b10, 8'hC0);
      set_vec(2, 8'h81, 3'd2, 2'b10, 8'h60);
      set_vec(3, 8'h81, 3'd3, 2'b10, 8'h30);
      set_vec(4, 8'h81, 3'd4, 2'b10, 8'h18);
      set_vec(5, 8'h81, 3'd5, 2'b10, 8'h0C);
      set_vec(6, 8'h81, 3'd6, 2'b10, 8'h06);
      set_vec(7, 8'h81, 3'd7, 2'b10, 8'h03);
      run8(8, 100, 0, 1'b1);

      // Backpressure: 10 mixed words, consumer stalled cycles 2..7
      set_vec(0, 8'hB4, 3'd3, 2'b00, 8'h16);
      set_vec(1, 8'hB4, 3'd3, 2'b01, 8'hF6);
      set_vec(2, 8'hB4, 3'd3, 2'b10, 8'h96);
      set_vec(3, 8'hB4, 3'd3, 2'b11, 8'hA0);
      set_vec(4, 8'h81, 3'd1, 2'b10, 8'hC0);
      set_vec(5, 8'h80, 3'd7, 2'b01, 8'hFF);
      set_vec(6, 8'hFF, 3'd4, 2'b00, 8'h0F);
      set_vec(7, 8'h0F, 3'd4, 2'b11, 8'hF0);
      set_vec(8, 8'h12, 3'd0, 2'b01, 8'h12);
      set_vec(9, 8'h01, 3'd5, 2'b10, 8'h08);
      run8(10, 2, 7, 1'b0);

      // Full pipe, same-cycle turnover
      cyc8(1'b1, 8'h81, 3'd1, 2'b10, 1'b0);
      check("fill_rdy", {31'b0, i8_rdy}, 1);
      cyc8(1'b1, 8'hFF, 3'd4, 2'b00, 1'b0);
      cyc8(1'b1, 8'h0F, 3'd4, 2'b11, 1'b0);
      cyc8(1'b1, 8'h80, 3'd7, 2'b01, 1'b0);
      check("full_in_rdy", {31'b0, i8_rdy}, 0);
      check("full_out_dat", {24'b0, o8_dat}, 32'hC0);
      cyc8(1'b1, 8'h80, 3'd7, 2'b01, 1'b1);
      check("turn_in_rdy", {31'b0, i8_rdy}, 1);
      check("turn_out_dat", {24'b0, o8_dat}, 32'hC0);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("turn_busy", {31'b0, busy8}, 1);
      check("turn_out2", {24'b0, o8_dat}, 32'h0F);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("turn_out3", {24'b0, o8_dat}, 32'hF0);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("turn_out4", {24'b0, o8_dat}, 32'hFF);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("drain_vld", {31'b0, o8_vld}, 0);
      check("drain_busy", {31'b0, busy8}, 0);

      // Reset mid-operation with three words in flight
      cyc8(1'b1, 8'hB4, 3'd3, 2'b00, 1'b0);
      cyc8(1'b1, 8'hB4, 3'd3, 2'b10, 1'b0);
      cyc8(1'b1, 8'hB4, 3'd3, 2'b11, 1'b0);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b0);
      check("pre_rst_busy", {31'b0, busy8}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_vld", {31'b0, o8_vld}, 0);
      check("mid_rst_busy", {31'b0, busy8}, 0);
      check("mid_rst_dat", {24'b0, o8_dat}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("post_rst_vld", {31'b0, o8_vld}, 0);
      cyc8(1'b1, 8'hB4, 3'd3, 2'b01, 1'b1);
      check("post_rst_rdy", {31'b0, i8_rdy}, 1);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("stale_vld_a", {31'b0, o8_vld}, 0);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("stale_vld_b", {31'b0, o8_vld}, 0);
      cyc8(1'b0, 8'h00, 3'd0, 2'b00, 1'b1);
      check("post_rst_out_vld", {31'b0, o8_vld}, 1);
      check("post_rst_out_dat", {24'b0, o8_dat}, 32'hF6);

      // Width N=32: ASR 31 then LSL 31, latency 5
      cyc32(1'b1, 32'h8000_0001, 5'd31, 2'b01, 1'b1);
      check("n32_in_rdy", {31'b0, i32_rdy}, 1);
      cyc32(1'b1, 32'h8000_0001, 5'd31, 2'b11, 1'b1);
      check("n32_vld_c2", {31'b0, o32_vld}, 0);
      for (int i = 3; i <= 8; i++) begin
         cyc32(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
         check("n32_vld", {31'b0, o32_vld}, {31'b0, (i == 6) || (i == 7)});
         if (i == 6) check("n32_asr31", o32_dat, 32'hFFFF_FFFF);
         if (i == 7) check("n32_lsl31", o32_dat, 32'h8000_0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
